// File: rtl/serial_subtractor32_if.sv
// Operand/result bundle for the bit-serial subtractor: request side drives
// start and operands, the subtractor returns status and held results.
interface serial_subtractor32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, in1, in2, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, in1, in2, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor32.sv
// Bit-serial diff = in1 - in2 - bin, one bit per clock; WIDTH cycles after the
// accepting edge. start is ignored while busy; results hold until the next completion.
module serial_subtractor32 #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  serial_subtractor32_if.slave sub
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy;
  logic             sum;
  logic             cout;
  logic             nb;

  // Subtraction as A + ~B + ~bin: the carry chain holds the inverted borrow.
  assign nb   = ~b_q[0];
  assign sum  = a_q[0] ^ nb ^ carry_q;
  assign cout = (a_q[0] & nb) | (carry_q & (a_q[0] ^ nb));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sub.start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (sub.start) begin
        a_d     = sub.in1;
        b_d     = sub.in2;
        carry_d = ~sub.bin;
        cnt_d   = '0;
      end
    end else begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      acc_d   = {sum, acc_q[WIDTH-1:1]};
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        // On the last bit A[0]/B[0] are the operand MSBs and sum is the result MSB.
        diff_d = {sum, acc_q[WIDTH-1:1]};
        bout_d = ~cout;
        ovf_d  = (a_q[0] ^ b_q[0]) & (sum ^ a_q[0]);
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  assign sub.busy = busy;
  assign sub.done = done_q;
  assign sub.diff = diff_q;
  assign sub.bout = bout_q;
  assign sub.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed bench for serial_subtractor32: hand-computed vectors, handshake timing,
// busy-start rejection, restart in the done cycle, async abort, reference-model sweep.
module tb_serial_subtractor32;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [W-1:0] prev_diff;
  logic         prev_bout;
  logic         prev_ovf;

  serial_subtractor32_if #(.WIDTH(W)) sub_if ();

  serial_subtractor32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .sub   (sub_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch at the next falling edge, then follow every edge up to completion.
  // glitch > 0 pulses start with other operands during that busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] ed, input logic eb,
                        input logic eo, input int glitch);
    logic ok;
    @(negedge clk);
    sub_if.start = 1'b1;
    sub_if.in1   = a;
    sub_if.in2   = b;
    sub_if.bin   = bi;
    @(posedge clk);
    #1;
    chk({tag, " accept"}, {61'd0, sub_if.busy, sub_if.done, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
    ok = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      sub_if.start = (i == glitch);
      sub_if.in1   = (i == glitch) ? 32'h1 : $urandom;
      sub_if.in2   = (i == glitch) ? 32'h2 : $urandom;
      sub_if.bin   = 1'($urandom_range(0, 1));
      if (i == W) sub_if.start = 1'b0;
      @(posedge clk);
      #1;
      if (i < W) begin
        if (sub_if.busy !== 1'b1 || sub_if.done !== 1'b0 || sub_if.diff !== prev_diff ||
            sub_if.bout !== prev_bout || sub_if.ovf !== prev_ovf)
          ok = 1'b0;
      end
    end
    chk({tag, " run hold"}, {63'd0, ok}, 64'd1);
    chk({tag, " busy/done"}, {62'd0, sub_if.busy, sub_if.done}, {62'd0, 1'b0, 1'b1});
    chk({tag, " diff"}, {32'd0, sub_if.diff}, {32'd0, ed});
    chk({tag, " bout/ovf"}, {62'd0, sub_if.bout, sub_if.ovf}, {62'd0, eb, eo});
    prev_diff = ed;
    prev_bout = eb;
    prev_ovf  = eo;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " idle"}, {30'd0, sub_if.busy, sub_if.done, sub_if.diff},
        {30'd0, 1'b0, 1'b0, prev_diff});
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rbi;
    logic         seen;
    checks = 0;
    errors = 0;
    prev_diff = '0;
    prev_bout = 1'b0;
    prev_ovf  = 1'b0;
    sub_if.start = 1'b0;
    sub_if.in1   = '0;
    sub_if.in2   = '0;
    sub_if.bin   = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset state", {28'd0, sub_if.busy, sub_if.done, sub_if.bout, sub_if.ovf, sub_if.diff}, 64'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    run_op("v1 7000-7fff", 32'h7000_0000, 32'h7FFF_FFFF, 1'b0, 32'hF000_0001, 1'b1, 1'b0, 0);
    run_op("v2 8000-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run_op("v3 5-5-1", 32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("v4 5-5-0", 32'd5, 32'd5, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 0);
    run_op("v5 in2=0", 32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 0);
    run_op("v6 ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("v7 0-0-1", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("v8 7fff-(-1)", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 0);

    run_op("busy start", 32'h10, 32'h3, 1'b0, 32'h0000_000D, 1'b0, 1'b0, 5);
    idle_check("no queued op");
    run_op("pre restart", 32'h10, 32'h3, 1'b0, 32'h0000_000D, 1'b0, 1'b0, 0);
    run_op("done restart", 32'h1, 32'h2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    idle_check("after restart");

    // Abort mid-run with a reset that lands between clock edges.
    @(negedge clk);
    sub_if.start = 1'b1;
    sub_if.in1   = 32'hFFFF_FFFF;
    sub_if.in2   = 32'h1;
    sub_if.bin   = 1'b0;
    @(posedge clk);
    #1;
    sub_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async abort", {28'd0, sub_if.busy, sub_if.done, sub_if.bout, sub_if.ovf, sub_if.diff}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (sub_if.done !== 1'b0 || sub_if.busy !== 1'b0 || sub_if.diff !== '0) seen = 1'b1;
    end
    chk("no done after abort", {63'd0, seen}, 64'd0);
    prev_diff = '0;
    prev_bout = 1'b0;
    prev_ovf  = 1'b0;
    run_op("fresh 2-1", 32'h2, 32'h1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbi  = 1'($urandom_range(0, 1));
      if (n % 4 == 1) rb = ra;
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
      run_op("sweep", ra, rb, rbi, full[W-1:0], full[W],
             (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]), 0);
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
